// File: rtl/enemy_path_pkg.sv
// Shared encodings for the enemy path sequencer.
//   mode_e  : segment traversal mode requested by the game-state controller
//   state_e : sequencer run/park state
package enemy_path_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'b00,
        MODE_PINGPONG = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_RSVD     = 2'b11   // behaves as loop
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running clock divider producing a one-cycle tick every DIV enabled cycles.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset, counter to 0
//   en_i   : 1 = count, 0 = freeze count
//   clr_i  : synchronous clear to 0, overrides en_i
//   tick_o : high while the counter sits at DIV-1 and en_i is high
module tick_gen #(
    parameter int DIV   = 1000000,
    parameter int CNT_W = 21
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/enemy_path_seq.sv
// Enemy path ROM address sequencer: walks one per-level segment of the path ROM
// at a divided tick rate in loop, ping-pong or one-shot mode.
//   pclk       : pixel clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : 1 = run, 0 = freeze tick counter and address
//   level      : requested level, latched on level_load (clamped to 1..MAX_LEVEL)
//   mode       : requested mode, latched on level_load
//   level_load : restart the segment with the new level/mode
//   addr       : registered ROM address = segment base + offset
//   step       : one-cycle pulse after each address advance
//   wrap       : one-cycle pulse after a segment end is reached
//   done       : one-shot finished, address parked
//   busy       : sequencer in RUN
//
// state   | meaning
// ST_RUN  | ticks advance the offset
// ST_HOLD | one-shot reached the segment end; ticks ignored until level_load
module enemy_path_seq
    import enemy_path_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int LEVEL_W   = 4,
    parameter int SEG_LEN   = 150,
    parameter int MAX_LEVEL = 10,
    parameter int TICK_DIV  = 1000000,
    parameter int CNT_W     = 21
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               en,
    input  logic [LEVEL_W-1:0] level,
    input  logic [1:0]         mode,
    input  logic               level_load,
    output logic [ADDR_W-1:0]  addr,
    output logic               step,
    output logic               wrap,
    output logic               done,
    output logic               busy
);

    localparam int OFF_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
    localparam int BW    = ADDR_W + LEVEL_W;

    localparam logic [OFF_W-1:0]   OFF_LAST = OFF_W'(SEG_LEN - 1);
    // Ping-pong turn targets; a one-entry segment never leaves offset 0.
    localparam logic [OFF_W-1:0]   PP_TOP   = OFF_W'((SEG_LEN > 1) ? SEG_LEN - 2 : 0);
    localparam logic [OFF_W-1:0]   PP_BOT   = OFF_W'((SEG_LEN > 1) ? 1 : 0);
    localparam logic [LEVEL_W-1:0] LVL_ONE  = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(MAX_LEVEL);

    generate
        if (SEG_LEN * MAX_LEVEL > 2 ** ADDR_W) begin : g_chk_rom
            $error("enemy_path_seq: SEG_LEN*MAX_LEVEL exceeds the ROM address space");
        end
        if (TICK_DIV < 2 || 2 ** CNT_W < TICK_DIV) begin : g_chk_div
            $error("enemy_path_seq: TICK_DIV must be >= 2 and fit in CNT_W bits");
        end
    endgenerate

    function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] lv);
        if (lv == '0) begin
            return LVL_ONE;
        end else if (lv > LVL_MAX) begin
            return LVL_MAX;
        end
        return lv;
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(input logic [LEVEL_W-1:0] lv);
        logic [BW-1:0] prod;
        prod = BW'(SEG_LEN) * (BW'(lv) - BW'(1));
        return prod[ADDR_W-1:0];
    endfunction

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic               dir_up_q, dir_up_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;
    logic               tick;

    tick_gen #(
        .DIV   (TICK_DIV),
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk_i  (pclk),
        .rst_i  (rst),
        .en_i   (en && (state_q == ST_RUN)),
        .clr_i  (level_load),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        level_d  = level_q;
        offset_d = offset_q;
        dir_up_d = dir_up_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;

        // A load in the same cycle as a tick discards the tick.
        if (level_load) begin
            level_d  = clamp_level(level);
            mode_d   = mode_e'(mode);
            offset_d = '0;
            dir_up_d = 1'b1;
            state_d  = ST_RUN;
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_PINGPONG: begin
                    if (dir_up_q) begin
                        if (offset_q == OFF_LAST) begin
                            offset_d = PP_TOP;
                            dir_up_d = (SEG_LEN == 1);
                            wrap_d   = 1'b1;
                        end else begin
                            offset_d = offset_q + 1'b1;
                        end
                    end else if (offset_q == '0) begin
                        offset_d = PP_BOT;
                        dir_up_d = 1'b1;
                        wrap_d   = 1'b1;
                    end else begin
                        offset_d = offset_q - 1'b1;
                    end
                end
                MODE_ONESHOT: begin
                    offset_d = (offset_q == OFF_LAST) ? offset_q : offset_q + 1'b1;
                    if (offset_d == OFF_LAST) begin
                        state_d = ST_HOLD;
                        wrap_d  = 1'b1;
                    end
                end
                default: begin
                    if (offset_q == OFF_LAST) begin
                        offset_d = '0;
                        wrap_d   = 1'b1;
                    end else begin
                        offset_d = offset_q + 1'b1;
                    end
                end
            endcase
        end

        addr_d = base_of(level_d) + ADDR_W'(offset_d);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            mode_q   <= MODE_LOOP;
            level_q  <= LVL_ONE;
            offset_q <= '0;
            dir_up_q <= 1'b1;
            addr_q   <= '0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            level_q  <= level_d;
            offset_q <= offset_d;
            dir_up_q <= dir_up_d;
            addr_q   <= addr_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
        end
    end

    assign addr = addr_q;
    assign step = step_q;
    assign wrap = wrap_q;
    assign done = (state_q == ST_HOLD);
    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_enemy_path_seq.sv
// Directed bench for enemy_path_seq with SEG_LEN=5, TICK_DIV=4, MAX_LEVEL=3.
// Each table record holds the inputs applied before a rising edge and the
// outputs expected just after it.
module tb_enemy_path_seq;

    localparam int ADDR_W    = 12;
    localparam int LEVEL_W   = 4;
    localparam int SEG_LEN   = 5;
    localparam int MAX_LEVEL = 3;
    localparam int TICK_DIV  = 4;
    localparam int CNT_W     = 3;

    logic               pclk = 1'b0;
    logic               rst;
    logic               en;
    logic [LEVEL_W-1:0] level;
    logic [1:0]         mode;
    logic               level_load;
    logic [ADDR_W-1:0]  addr;
    logic               step, wrap, done, busy;

    always #5 pclk = ~pclk;

    enemy_path_seq #(
        .ADDR_W    (ADDR_W),
        .LEVEL_W   (LEVEL_W),
        .SEG_LEN   (SEG_LEN),
        .MAX_LEVEL (MAX_LEVEL),
        .TICK_DIV  (TICK_DIV),
        .CNT_W     (CNT_W)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .en         (en),
        .level      (level),
        .mode       (mode),
        .level_load (level_load),
        .addr       (addr),
        .step       (step),
        .wrap       (wrap),
        .done       (done),
        .busy       (busy)
    );

    typedef struct {
        logic               en;
        logic               load;
        logic [LEVEL_W-1:0] level;
        logic [1:0]         mode;
        logic [ADDR_W-1:0]  addr;
        logic               step;
        logic               wrap;
        logic               done;
        logic               busy;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s [vec %0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    function automatic void push(input bit e, input bit ld, input int lv, input int md,
                                 input int a, input bit s, input bit w, input bit d, input bit b);
        vec_t v;
        v.en    = e;
        v.load  = ld;
        // Non-load records carry changing level/mode values that must be ignored.
        v.level = ld ? LEVEL_W'(lv) : LEVEL_W'(vecs.size());
        v.mode  = ld ? 2'(md) : 2'(vecs.size());
        v.addr  = ADDR_W'(a);
        v.step  = s;
        v.wrap  = w;
        v.done  = d;
        v.busy  = b;
        vecs.push_back(v);
    endfunction

    function automatic void hold(input int a, input bit e, input bit d);
        push(e, 1'b0, 0, 0, a, 1'b0, 1'b0, d, !d);
    endfunction

    // Three idle cycles followed by the tick edge that moves old_a -> new_a.
    function automatic void grp(input int old_a, input int new_a, input bit w, input bit d_after);
        for (int k = 0; k < 3; k++) hold(old_a, 1'b1, 1'b0);
        push(1'b1, 1'b0, 0, 0, new_a, 1'b1, w, d_after, !d_after);
    endfunction

    function automatic void ld(input int lv, input int md, input int a);
        push(1'b1, 1'b1, lv, md, a, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        level_load = 1'b0;
        level      = '0;
        mode       = '0;

        // Loop, level 1, straight out of reset.
        grp(0, 1, 0, 0); grp(1, 2, 0, 0); grp(2, 3, 0, 0); grp(3, 4, 0, 0); grp(4, 0, 1, 0);
        // Ping-pong, level 2.
        ld(2, 1, 5);
        grp(5, 6, 0, 0); grp(6, 7, 0, 0); grp(7, 8, 0, 0); grp(8, 9, 0, 0); grp(9, 8, 1, 0);
        grp(8, 7, 0, 0); grp(7, 6, 0, 0); grp(6, 5, 0, 0); grp(5, 6, 1, 0);
        // One-shot, level 3, then parked.
        ld(3, 2, 10);
        grp(10, 11, 0, 0); grp(11, 12, 0, 0); grp(12, 13, 0, 0); grp(13, 14, 1, 1);
        for (int k = 0; k < 20; k++) hold(14, 1'b1, 1'b1);
        ld(1, 0, 0);
        // Pause at addr 2 with one count already consumed.
        grp(0, 1, 0, 0); grp(1, 2, 0, 0);
        hold(2, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) hold(2, 1'b0, 1'b0);
        hold(2, 1'b1, 1'b0);
        hold(2, 1'b1, 1'b0);
        push(1'b1, 1'b0, 0, 0, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        // Load coincident with the tick at addr 3, then clamp cases.
        for (int k = 0; k < 3; k++) hold(3, 1'b1, 1'b0);
        ld(2, 0, 5);
        grp(5, 6, 0, 0);
        ld(0, 0, 0);
        ld(7, 0, 10);
        grp(10, 11, 0, 0);
        // One-shot up to addr 13 before the async reset.
        ld(3, 2, 10);
        grp(10, 11, 0, 0); grp(11, 12, 0, 0); grp(12, 13, 0, 0);

        #2;
        chk("reset addr", -1, 32'(addr), 0);
        chk("reset step", -1, 32'(step), 0);
        chk("reset wrap", -1, 32'(wrap), 0);
        chk("reset done", -1, 32'(done), 0);
        chk("reset busy", -1, 32'(busy), 1);

        repeat (2) @(negedge pclk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en         = vecs[i].en;
            level_load = vecs[i].load;
            level      = vecs[i].level;
            mode       = vecs[i].mode;
            @(posedge pclk);
            #1;
            chk("addr", i, 32'(addr), 32'(vecs[i].addr));
            chk("step", i, 32'(step), 32'(vecs[i].step));
            chk("wrap", i, 32'(wrap), 32'(vecs[i].wrap));
            chk("done", i, 32'(done), 32'(vecs[i].done));
            chk("busy", i, 32'(busy), 32'(vecs[i].busy));
        end
        level_load = 1'b0;

        // Async reset at addr 13 between edges.
        #2 rst = 1'b1;
        #1;
        chk("async rst addr", 1000, 32'(addr), 0);
        chk("async rst step", 1000, 32'(step), 0);
        chk("async rst done", 1000, 32'(done), 0);
        chk("async rst busy", 1000, 32'(busy), 1);
        @(negedge pclk);
        rst   = 1'b0;
        en    = 1'b1;
        level = 4'd3;
        mode  = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            @(posedge pclk);
            #1;
            chk("post rst addr", 1000 + k, 32'(addr), (k == 4) ? 1 : 0);
            chk("post rst step", 1000 + k, 32'(step), (k == 4) ? 1 : 0);
            chk("post rst wrap", 1000 + k, 32'(wrap), 0);
        end

        // Async reset while parked clears done.
        @(negedge pclk);
        level_load = 1'b1;
        @(posedge pclk);
        #1;
        level_load = 1'b0;
        chk("reload addr", 2000, 32'(addr), 10);
        repeat (16) @(posedge pclk);
        #1;
        chk("parked addr", 2001, 32'(addr), 14);
        chk("parked done", 2001, 32'(done), 1);
        chk("parked busy", 2001, 32'(busy), 0);
        #2 rst = 1'b1;
        #1;
        chk("rst parked addr", 2002, 32'(addr), 0);
        chk("rst parked done", 2002, 32'(done), 0);
        chk("rst parked busy", 2002, 32'(busy), 1);
        @(negedge pclk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
